dec4to16_strobe: RTL and testbench

- Registered 4-to-16 one-hot decoder and strobe generator; the inverse of the 16-to-4 encoder block.
- Accepts a 4-bit code through a valid/ready handshake.
- Drives the matching one-hot select line for exactly PULSE_LEN cycles, then enforces a GAP_LEN-cycle all-zero gap before accepting the next code.
- Drives select/strobe lines into the 16-way fabric that the encoder later compresses back to binary.

---
 rtl/dec_strobe_pkg.sv | 15 +
 rtl/dec4to16_strobe_if.sv | 22 ++
 rtl/dec4to16_comb.sv | 18 +
 rtl/dec4to16_strobe.sv | 114 +++++++++++
 tb/tb_dec4to16_strobe.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dec_strobe_pkg.sv
// Shared types and widths for the 4-to-16 strobe decoder
// and the matching 16-to-4 encoder.
package dec_strobe_pkg;

    localparam int CODE_W = 4;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

endpackage

// File: rtl/dec4to16_strobe_if.sv
// Code-in handshake: the source holds valid/code until
// it sees ready in the same cycle.
interface dec4to16_strobe_if;
    import dec_strobe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] binary_in;

    modport master (
        output in_valid,
        output binary_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  binary_in,
        output in_ready
    );

endinterface

// File: rtl/dec4to16_comb.sv
// Combinational 4-bit to one-hot decoder; all-zero
// output while en is low.
module dec4to16_comb
    import dec_strobe_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/dec4to16_strobe.sv
// Registered one-hot strobe generator: PULSE_LEN cycles
// of the decoded line, then GAP_LEN zero cycles.
module dec4to16_strobe
    import dec_strobe_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    dec4to16_strobe_if.slave     in_if,
    output logic [OUT_W-1:0]     decoder_out,
    output logic                 busy,
    output logic                 done
);

    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse
        $error("PULSE_LEN must be in 1..255");
    end
    if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap
        $error("GAP_LEN must be in 0..255");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   =
        (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              done_q, done_d;
    logic              accept;
    logic [OUT_W-1:0]  onehot;

    assign in_if.in_ready = (state_q == IDLE) && enable && !reset;
    assign accept         = in_if.in_valid && in_if.in_ready;

    dec4to16_comb u_dec (
        .en     (accept),
        .code   (in_if.binary_in),
        .onehot (onehot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    out_d   = onehot;
                    state_d = ACTIVE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            ACTIVE: begin
                // Abort takes priority over a completing strobe.
                if (!enable) begin
                    out_d   = '0;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    out_d  = '0;
                    done_d = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                out_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                out_d   = '0;
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign decoder_out = out_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dec4to16_strobe.sv
// Two strobe decoders (4/1 and 1/0 timing) run against a
// time-window reference model with directed and random traffic.
module tb_dec4to16_strobe;
    import dec_strobe_pkg::*;

    localparam int PA = 4;
    localparam int GA = 1;
    localparam int PB = 1;
    localparam int GB = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] out_a, out_b;
    logic        busy_a, busy_b, done_a, done_b;

    dec4to16_strobe_if if_a ();
    dec4to16_strobe_if if_b ();

    dec4to16_strobe #(.PULSE_LEN(PA), .GAP_LEN(GA)) u_a (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_if       (if_a.slave),
        .decoder_out (out_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    dec4to16_strobe #(.PULSE_LEN(PB), .GAP_LEN(GB)) u_b (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_if       (if_b.slave),
        .decoder_out (out_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int pl [2] = '{PA, PB};
    int gl [2] = '{GA, GB};
    bit has[2];
    int st [2];
    int cd [2];
    int dcy[2];

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit busy_m(input int d);
        return has[d] && (cyc <= st[d] + pl[d] + gl[d]);
    endfunction

    task automatic expect_dut(input int d, input logic [15:0] o,
                              input logic rdy, input logic bsy,
                              input logic dn);
        logic [15:0] eo;
        eo = '0;
        if (has[d] && cyc <= st[d] + pl[d])
            eo = 16'd1 << cd[d];
        check($sformatf("out%0d", d), 32'(o), 32'(eo));
        check($sformatf("busy%0d", d), 32'(bsy), 32'(busy_m(d)));
        check($sformatf("ready%0d", d), 32'(rdy),
              32'(!busy_m(d) && enable && !reset));
        check($sformatf("done%0d", d), 32'(dn), 32'(dcy[d] == cyc));
        if (eo != '0)
            check($sformatf("roundtrip%0d", d), $clog2(o), cd[d]);
    endtask

    task automatic model_edge(input int d, input bit vld,
                              input logic [3:0] code, output bit acc);
        acc = 1'b0;
        if (reset) begin
            has[d] = 1'b0;
            dcy[d] = -1;
        end else if (!enable) begin
            if (busy_m(d)) begin
                has[d] = 1'b0;
                dcy[d] = -1;
            end
        end else if (!busy_m(d) && vld) begin
            acc    = 1'b1;
            has[d] = 1'b1;
            st[d]  = cyc;
            cd[d]  = int'(code);
            dcy[d] = cyc + pl[d] + 1;
        end
    endtask

    task automatic step();
        bit acc_a, acc_b;
        if_a.in_valid  = (q_a.size() > 0);
        if_a.binary_in = (q_a.size() > 0) ? q_a[0] : 4'h0;
        if_b.in_valid  = (q_b.size() > 0);
        if_b.binary_in = (q_b.size() > 0) ? q_b[0] : 4'h0;
        @(negedge clk);
        expect_dut(0, out_a, if_a.in_ready, busy_a, done_a);
        expect_dut(1, out_b, if_b.in_ready, busy_b, done_b);
        model_edge(0, if_a.in_valid, if_a.binary_in, acc_a);
        model_edge(1, if_b.in_valid, if_b.binary_in, acc_b);
        @(posedge clk);
        #1;
        if (acc_a) void'(q_a.pop_front());
        if (acc_b) void'(q_b.pop_front());
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q_a.size() > 0 || q_b.size() > 0 ||
                busy_m(0) || busy_m(1)) && n < 400) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n >= 400), 32'd0);
        step();
    endtask

    task automatic wait_accept_a();
        int n = 0;
        while (q_a.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("accept_timeout", 32'(n >= 100), 32'd0);
    endtask

    initial begin
        has = '{1'b0, 1'b0};
        dcy = '{-1, -1};
        st  = '{0, 0};
        cd  = '{0, 0};
        reset  = 1'b1;
        enable = 1'b1;
        if_a.in_valid  = 1'b0;
        if_a.binary_in = 4'h0;
        if_b.in_valid  = 1'b0;
        if_b.binary_in = 4'h0;
        @(posedge clk);
        #1;

        q_a.push_back(4'h5);
        q_b.push_back(4'h5);
        repeat (3) step();
        q_a.delete();
        q_b.delete();
        reset = 1'b0;
        step();

        q_a.push_back(4'hA);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            q_a.push_back(4'(i));
            q_b.push_back(4'(i));
        end
        wait_idle();

        q_b.push_back(4'h3);
        q_b.push_back(4'h7);
        wait_idle();

        q_a.push_back(4'hC);
        wait_accept_a();
        step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        wait_idle();

        q_a.push_back(4'h1);
        wait_accept_a();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        q_a.push_back(4'hA);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 20) != 0;
            reset  = ($urandom % 100) == 0;
            if (q_a.size() == 0 && ($urandom % 3) == 0)
                q_a.push_back(4'($urandom % 16));
            if (q_b.size() == 0 && ($urandom % 3) == 0)
                q_b.push_back(4'($urandom % 16));
            step();
        end
        reset  = 1'b0;
        enable = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
